truth_table_scanner: RTL and testbench

Sequential stimulus/response stage for the three-input combinational modules of Guide 6, such as the x·(¬y + ¬z) function. On `start`, it drives every input combination {x,y,z} = 0..7 onto the combinational block's inputs and holds each for a programmable settle time. It then samples the block's output `s` and assembles an 8-bit truth-table word, which it compares with a parameterised expected word. It sits directly around the combinational module, feeding its inputs and consuming its output, and replaces the hand-written `#1` stimulus sequences in testbenches with synthesizable hardware.

---
 rtl/truth_table_scanner.sv | 88 ++++++++
 tb/tb_truth_table_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Sequential stimulus/response stage for 3-input combinational blocks: walks {x,y,z}
// through rows 0..7, samples s after a programmable settle time and grades the truth table.
//
// state | meaning
// IDLE  | waiting for start; results of the last scan held
// SCAN  | driving row, counting settle cycles, sampling s
// DONE  | one-cycle completion pulse, then back to IDLE
module truth_table_scanner #(
  parameter logic [7:0]  EXPECTED = 8'b0111_0000,
  parameter int unsigned SETTLE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_word,
  output logic       match,
  output logic [7:0] err_mask
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [2:0] row;
  logic [3:0] cnt;
  logic [7:0] sampled;

  // Table as it will look once the current row's sample is written in.
  always_comb begin
    sampled      = table_word;
    sampled[row] = s;
  end

  assign {x, y, z} = row;
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= 3'd0;
      cnt        <= 4'd0;
      table_word <= 8'd0;
      match      <= 1'b0;
      err_mask   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row        <= 3'd0;
            cnt        <= 4'd0;
            table_word <= 8'd0;
            match      <= 1'b0;
            err_mask   <= 8'd0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 4'd1;
          end else begin
            cnt        <= 4'd0;
            table_word <= sampled;
            if (row == 3'd7) begin
              match    <= (sampled == EXPECTED);
              err_mask <= sampled ^ EXPECTED;
              state    <= DONE;
            end else begin
              row <= row + 3'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: drivers push expected results per accepted start,
// monitors pop and grade them whenever done pulses.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b;
  logic [1:0] fn_sel;

  logic       s_a, x_a, y_a, z_a, busy_a, done_a, match_a;
  logic [7:0] tbl_a, err_a;
  logic       s_b, x_b, y_b, z_b, busy_b, done_b, match_b;
  logic [7:0] tbl_b, err_b;

  // Block under scan for the SETTLE=1 instance: Guide 6 function, stuck-at-0, or s = x.
  always_comb begin
    s_a = 1'b0;
    case (fn_sel)
      2'd0:    s_a = (x_a & ~z_a) | (x_a & ~y_a);
      2'd1:    s_a = 1'b0;
      default: s_a = x_a;
    endcase
  end
  assign s_b = (x_b & ~z_b) | (x_b & ~y_b);

  truth_table_scanner #(.EXPECTED(8'h70), .SETTLE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .s(s_a),
    .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a),
    .table_word(tbl_a), .match(match_a), .err_mask(err_a)
  );

  truth_table_scanner #(.EXPECTED(8'h70), .SETTLE(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .s(s_b),
    .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b),
    .table_word(tbl_b), .match(match_b), .err_mask(err_b)
  );

  typedef struct {
    logic [7:0] tbl;
    logic       m;
    logic [7:0] err;
    int         dc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic grade(input string tag, input exp_t e, input logic [7:0] t,
                       input logic m, input logic [7:0] er);
    chk({tag, "_table"},    {24'd0, t},  {24'd0, e.tbl});
    chk({tag, "_match"},    {31'd0, m},  {31'd0, e.m});
    chk({tag, "_err_mask"}, {24'd0, er}, {24'd0, e.err});
    chk({tag, "_done_cyc"}, cyc,         e.dc);
  endtask

  // Monitors: grade every done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("busy_done_excl_a", {31'd0, busy_a & done_a}, 32'd0);
      chk("busy_done_excl_b", {31'd0, busy_b & done_b}, 32'd0);
      if (done_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done_a: got done at cycle %0d expected none", cyc);
        end else begin
          e = q_a.pop_front();
          grade("a", e, tbl_a, match_a, err_a);
        end
      end
      if (done_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done_b: got done at cycle %0d expected none", cyc);
        end else begin
          e = q_b.pop_front();
          grade("b", e, tbl_b, match_b, err_b);
        end
      end
    end
  end

  task automatic pulse_a(output int e0);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start_a = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] t, input logic m, input logic [7:0] er, input int dc);
    exp_t e;
    e.tbl = t; e.m = m; e.err = er; e.dc = dc;
    q_a.push_back(e);
  endtask

  // One SETTLE=1 scan; optionally re-pulses start while row == poke_row.
  task automatic scan_a(input logic [1:0] fn, input logic [7:0] t, input logic m,
                        input logic [7:0] er, input int poke_row);
    int e0;
    fn_sel = fn;
    pulse_a(e0);
    push_a(t, m, er, e0 + 8);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("xyz_a", {29'd0, x_a, y_a, z_a}, k);
      chk("busy_a", {31'd0, busy_a}, 32'd1);
      start_a = (k == poke_row);
    end
    start_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done_a(input int lim);
    int n = 0;
    while (!done_a && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) begin
      checks++; errors++;
      $display("FAIL timeout_done_a: got no done expected one within %0d cycles", lim);
    end
    @(negedge clk);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_xyz"},  {29'd0, x_a, y_a, z_a}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
    chk({tag, "_tbl"},  {24'd0, tbl_a}, 32'd0);
    chk({tag, "_match"},{31'd0, match_a}, 32'd0);
    chk({tag, "_err"},  {24'd0, err_a}, 32'd0);
  endtask

  initial begin
    int e0;
    int busy_cnt;
    exp_t eb;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    fn_sel  = 2'd0;
    repeat (3) @(negedge clk);
    chk_zero_a("rst_a");
    chk("rst_b_outs", {14'd0, x_b, y_b, z_b, busy_b, done_b, tbl_b, match_b, err_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    scan_a(2'd0, 8'h70, 1'b1, 8'h00, -1);   // Guide 6 function
    scan_a(2'd1, 8'h00, 1'b0, 8'h70, -1);   // s stuck at 0
    scan_a(2'd2, 8'hF0, 1'b0, 8'h80, -1);   // s = x
    scan_a(2'd0, 8'h70, 1'b1, 8'h00, 3);    // start ignored mid-scan

    // Reset mid-scan at row 5: everything clears without waiting for a clock.
    fn_sel = 2'd0;
    pulse_a(e0);
    for (int k = 0; k < 6; k++) @(negedge clk);
    chk("pre_rst_row", {29'd0, x_a, y_a, z_a}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk_zero_a("async_rst");
    @(negedge clk);
    reset = 1'b0;
    scan_a(2'd0, 8'h70, 1'b1, 8'h00, -1);

    // Start held high: back-to-back scans every 8*SETTLE+2 cycles, results cleared on accept.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    chk("cont_clear_tbl",   {24'd0, tbl_a},   32'd0);
    chk("cont_clear_match", {31'd0, match_a}, 32'd0);
    push_a(8'h70, 1'b1, 8'h00, e0 + 8);
    for (int k = 1; k < 3; k++) begin
      repeat (9) @(posedge clk);
      #1;
      chk("cont_idle_busy", {31'd0, busy_a}, 32'd0);
      chk("cont_idle_done", {31'd0, done_a}, 32'd0);
      @(posedge clk);
      #1;
      chk("cont_acc_busy",  {31'd0, busy_a},  32'd1);
      chk("cont_acc_tbl",   {24'd0, tbl_a},   32'd0);
      chk("cont_acc_match", {31'd0, match_a}, 32'd0);
      push_a(8'h70, 1'b1, 8'h00, e0 + 10 * k + 8);
    end
    start_a = 1'b0;
    wait_done_a(20);

    // SETTLE = 3 instance: each row held 3 cycles, busy for 24, done at E0+24.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start_b = 1'b0;
    eb.tbl = 8'h70; eb.m = 1'b1; eb.err = 8'h00; eb.dc = e0 + 24;
    q_b.push_back(eb);
    busy_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("xyz_b", {29'd0, x_b, y_b, z_b}, k / 3);
      if (busy_b) busy_cnt++;
    end
    @(negedge clk);
    chk("busy_len_b", busy_cnt, 32'd24);
    chk("busy_end_b", {31'd0, busy_b}, 32'd0);
    chk("done_b_seen", {31'd0, done_b}, 32'd1);

    repeat (3) @(negedge clk);
    chk("pending_a", q_a.size(), 32'd0);
    chk("pending_b", q_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
